// File: rtl/fpu_pipeline_controller.sv
// Purpose: valid/stall sequencer for the multi-stage FPU datapath with one iterative divide stage.
// Latency: STAGES cycles for a plain op, STAGES + DIV_ITERATIONS + 1 for a divide/sqrt op.
// Backpressure: out_ready low holds valid stages back to the nearest bubble; in_ready = ~stall[0] & ~flush.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   flush                     synchronous kill of every in-flight op (wins over advance)
//   in_valid/in_division_op   requester op and its divide flag; in_ready accepts it
//   out_valid/out_ready       result handshake at stage STAGES
//   stall[i-1]                hold for stage i registers; stage_valid[i-1] = stage i occupied
//   division_active/_iteration/_last   iteration controls for the divider at DIV_STAGE
// Optional: define FPU_PERF_COUNTERS_EN to add perf_ops_retired, perf_div_cycles, perf_backpressure.
module fpu_pipeline_controller #(
    parameter int STAGES         = 4,
    parameter int DIV_STAGE      = 2,
    parameter int DIV_ITERATIONS = 13
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_division_op,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [STAGES-1:0] stall,
    output logic [STAGES-1:0] stage_valid,
    output logic              division_active,
    output logic [5:0]        division_iteration,
    output logic              division_last
`ifdef FPU_PERF_COUNTERS_EN
    ,
    output logic [31:0]       perf_ops_retired,
    output logic [31:0]       perf_div_cycles,
    output logic [31:0]       perf_backpressure
`endif
);

    // Zero-based bit index of the divide stage.
    localparam int         DS        = DIV_STAGE - 1;
    localparam logic [5:0] LAST_ITER = 6'(DIV_ITERATIONS - 1);

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_ITER = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    div_state_t        state_q, state_d;
    logic [5:0]        iter_q, iter_d;
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] div_q;
    logic [STAGES-1:0] hold;

    // Hold chain, output stage backward. An empty stage never holds, so a
    // downstream stall only propagates through contiguous valid stages.
    // The divide stage additionally holds its own op until the FSM reaches DONE.
    always_comb begin
        logic h;
        hold = '0;
        h = valid_q[STAGES-1] & ~out_ready;
        hold[STAGES-1] = h;
        for (int i = STAGES - 2; i >= 0; i--) begin
            if (i == DS) begin
                h = valid_q[i] & (h | (div_q[i] & (state_q != DIV_DONE)));
            end else begin
                h = valid_q[i] & h;
            end
            hold[i] = h;
        end
    end

    // Stage occupancy. A stage whose predecessor is held loads a bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            div_q   <= '0;
        end else if (flush) begin
            valid_q <= '0;
            div_q   <= '0;
        end else begin
            if (!hold[0]) begin
                valid_q[0] <= in_valid;
                div_q[0]   <= in_valid & in_division_op;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (!hold[i]) begin
                    valid_q[i] <= valid_q[i-1] & ~hold[i-1];
                    div_q[i]   <= div_q[i-1] & ~hold[i-1];
                end
            end
        end
    end

    // Divide FSM: state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= DIV_IDLE;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    // Divide FSM: next state. DONE always returns through IDLE, giving a fixed
    // one-cycle gap before a queued divide starts iterating. The counter runs
    // regardless of back-pressure; DONE simply waits for the op to drain.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        if (flush) begin
            state_d = DIV_IDLE;
            iter_d  = '0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    iter_d = '0;
                    if (valid_q[DS] & div_q[DS]) begin
                        state_d = DIV_ITER;
                    end
                end
                DIV_ITER: begin
                    if (iter_q == LAST_ITER) begin
                        state_d = DIV_DONE;
                    end else begin
                        iter_d = iter_q + 6'd1;
                    end
                end
                DIV_DONE: begin
                    if (!hold[DS+1]) begin
                        state_d = DIV_IDLE;
                        iter_d  = '0;
                    end
                end
                default: begin
                    state_d = DIV_IDLE;
                    iter_d  = '0;
                end
            endcase
        end
    end

    // Divide FSM: outputs.
    always_comb begin
        division_active    = (state_q == DIV_ITER);
        division_iteration = iter_q;
        division_last      = (state_q == DIV_ITER) && (iter_q == LAST_ITER);
    end

    assign stall       = hold;
    assign stage_valid = valid_q;
    assign out_valid   = valid_q[STAGES-1];
    assign in_ready    = ~hold[0] & ~flush;

`ifdef FPU_PERF_COUNTERS_EN
    // Free-running, wrap at 2^32; flush does not clear them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_ops_retired  <= '0;
            perf_div_cycles   <= '0;
            perf_backpressure <= '0;
        end else begin
            if (out_valid & out_ready) begin
                perf_ops_retired <= perf_ops_retired + 32'd1;
            end
            if (state_q == DIV_ITER) begin
                perf_div_cycles <= perf_div_cycles + 32'd1;
            end
            if (hold[STAGES-1]) begin
                perf_backpressure <= perf_backpressure + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fpu_pipeline_controller.sv
// Purpose: self-checking bench for fpu_pipeline_controller (STAGES=4, DIV_STAGE=2, DIV_ITERATIONS=13).
// Latency: directed scenarios check exact cycle counts; random phase compares every cycle to a slot model.
// Backpressure: out_ready and flush are exercised both directed and randomly.
module tb_fpu_pipeline_controller;

    localparam int S  = 4;
    localparam int D  = 2;
    localparam int DI = 13;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         flush;
    logic         in_valid;
    logic         in_division_op;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [S-1:0] stall;
    logic [S-1:0] stage_valid;
    logic         division_active;
    logic [5:0]   division_iteration;
    logic         division_last;
`ifdef FPU_PERF_COUNTERS_EN
    logic [31:0]  perf_ops_retired;
    logic [31:0]  perf_div_cycles;
    logic [31:0]  perf_backpressure;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fpu_pipeline_controller #(
        .STAGES(S),
        .DIV_STAGE(D),
        .DIV_ITERATIONS(DI)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .flush(flush),
        .in_valid(in_valid),
        .in_division_op(in_division_op),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .stall(stall),
        .stage_valid(stage_valid),
        .division_active(division_active),
        .division_iteration(division_iteration),
        .division_last(division_last)
`ifdef FPU_PERF_COUNTERS_EN
        ,
        .perf_ops_retired(perf_ops_retired),
        .perf_div_cycles(perf_div_cycles),
        .perf_backpressure(perf_backpressure)
`endif
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_division_op = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_division_op = 1'b0; out_ready = 1'b0;
        #3;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (stall !== 4'b0000) begin errors++; $display("FAIL reset_stall got %b exp 0000", stall); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (stage_valid !== 4'b0000) begin errors++; $display("FAIL reset_stage_valid got %b exp 0000", stage_valid); end
        checks++; if (division_active !== 1'b0 || division_iteration !== 6'd0 || division_last !== 1'b0) begin
            errors++; $display("FAIL reset_div got act=%b it=%0d last=%b exp 0/0/0", division_active, division_iteration, division_last);
        end
        // Run a divide and an add into the pipe, then pull reset mid-iteration.
        @(posedge clk); #1 reset_n = 1'b1;
        in_valid = 1'b1; in_division_op = 1'b1;
        next_cycle();
        in_division_op = 1'b0;
        repeat (4) next_cycle();
        in_valid = 1'b0;
        checks++; if (stage_valid !== 4'b0011 || division_active !== 1'b1) begin
            errors++; $display("FAIL midstream_setup got sv=%b act=%b exp 0011/1", stage_valid, division_active);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL async_reset_in_ready got %b exp 1", in_ready); end
        checks++; if (stall !== 4'b0000) begin errors++; $display("FAIL async_reset_stall got %b exp 0000", stall); end
        checks++; if (out_valid !== 1'b0 || stage_valid !== 4'b0000) begin
            errors++; $display("FAIL async_reset_valid got ov=%b sv=%b exp 0/0000", out_valid, stage_valid);
        end
        checks++; if (division_active !== 1'b0 || division_iteration !== 6'd0) begin
            errors++; $display("FAIL async_reset_div got act=%b it=%0d exp 0/0", division_active, division_iteration);
        end
        @(posedge clk); #1 reset_n = 1'b1;
        out_ready = 1'b1;
    endtask

    task automatic test_single_add();
        int lat;
        lat = -1;
        in_valid = 1'b1; in_division_op = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_accept got %b exp 1", in_ready); end
        next_cycle();
        in_valid = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin lat = k; break; end
            next_cycle();
        end
        checks++; if (lat != 4) begin errors++; $display("FAIL add_latency got %0d exp 4", lat); end
        next_cycle();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_retired got %b exp 0", out_valid); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        int first, last, cnt;
        first = -1; last = -1; cnt = 0;
        in_valid = 1'b1; in_division_op = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            if (k == 8) in_valid = 1'b0;
            @(negedge clk);
            if (k < 8) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready k=%0d got %b exp 1", k, in_ready); end
            end
            if (out_valid === 1'b1) begin
                if (first < 0) first = k;
                last = k; cnt++;
            end
            next_cycle();
        end
        checks++; if (cnt != 8) begin errors++; $display("FAIL b2b_count got %0d exp 8", cnt); end
        checks++; if (first != 4 || last != 11) begin errors++; $display("FAIL b2b_window got %0d..%0d exp 4..11", first, last); end
        // Fill the pipe with the consumer stalled.
        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_in_ready k=%0d got %b exp 1", k, in_ready); end
            next_cycle();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (stall !== 4'b1111 || in_ready !== 1'b0) begin
                errors++; $display("FAIL full_stall k=%0d got stall=%b rdy=%b exp 1111/0", k, stall, in_ready);
            end
            checks++; if (stage_valid !== 4'b1111 || out_valid !== 1'b1) begin
                errors++; $display("FAIL full_hold k=%0d got sv=%b ov=%b exp 1111/1", k, stage_valid, out_valid);
            end
            next_cycle();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++; if (out_valid !== (k < 4)) begin
                errors++; $display("FAIL drain k=%0d got %b exp %b", k, out_valid, (k < 4));
            end
            next_cycle();
        end
    endtask

    task automatic test_single_divide();
        int act_cnt, first_act, last_cyc, last_cnt, out_cyc, iter_bad, stall_bad;
        act_cnt = 0; first_act = -1; last_cyc = -1; last_cnt = 0; out_cyc = -1; iter_bad = 0; stall_bad = 0;
        in_valid = 1'b1; in_division_op = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL div_accept got %b exp 1", in_ready); end
        next_cycle();
        in_valid = 1'b0; in_division_op = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (division_active === 1'b1) begin
                if (first_act < 0) first_act = k;
                if (division_iteration !== 6'(k - first_act)) iter_bad++;
                if (stall[1] !== 1'b1) stall_bad++;
                act_cnt++;
            end
            if (division_last === 1'b1) begin last_cyc = k; last_cnt++; end
            if (out_valid === 1'b1 && out_cyc < 0) out_cyc = k;
            next_cycle();
        end
        checks++; if (first_act != 3) begin errors++; $display("FAIL div_start got %0d exp 3", first_act); end
        checks++; if (act_cnt != DI) begin errors++; $display("FAIL div_active_cycles got %0d exp %0d", act_cnt, DI); end
        checks++; if (iter_bad != 0) begin errors++; $display("FAIL div_iteration_seq got %0d bad exp 0", iter_bad); end
        checks++; if (stall_bad != 0) begin errors++; $display("FAIL div_stall1 got %0d bad exp 0", stall_bad); end
        checks++; if (last_cyc != 15 || last_cnt != 1) begin
            errors++; $display("FAIL div_last got cyc=%0d n=%0d exp 15/1", last_cyc, last_cnt);
        end
        checks++; if (out_cyc != S + DI + 1) begin errors++; $display("FAIL div_latency got %0d exp %0d", out_cyc, S + DI + 1); end
    endtask

    task automatic test_add_behind_divide();
        int outs[$];
        in_valid = 1'b1; in_division_op = 1'b1; out_ready = 1'b1;
        next_cycle();
        in_division_op = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL behind_accept got %b exp 1", in_ready); end
        next_cycle();
        in_valid = 1'b0;
        for (int k = 2; k <= 30; k++) begin
            @(negedge clk);
            if (k == 8) begin
                checks++; if (stage_valid !== 4'b0011 || stall !== 4'b0011 || in_ready !== 1'b0) begin
                    errors++; $display("FAIL behind_bubbles got sv=%b stall=%b rdy=%b exp 0011/0011/0", stage_valid, stall, in_ready);
                end
            end
            if (out_valid === 1'b1) outs.push_back(k);
            next_cycle();
        end
        checks++; if (outs.size() != 2) begin
            errors++; $display("FAIL behind_count got %0d exp 2", outs.size());
        end else if (outs[0] != 18 || outs[1] != 19) begin
            errors++; $display("FAIL behind_order got %0d,%0d exp 18,19", outs[0], outs[1]);
        end
    endtask

    task automatic test_two_divides();
        int rises[$], falls[$], outs[$];
        logic prev;
        prev = 1'b0;
        in_valid = 1'b1; in_division_op = 1'b1; out_ready = 1'b1;
        next_cycle();
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL two_div_accept got %b exp 1", in_ready); end
        next_cycle();
        in_valid = 1'b0; in_division_op = 1'b0;
        for (int k = 2; k <= 40; k++) begin
            @(negedge clk);
            if (division_active === 1'b1 && prev === 1'b0) rises.push_back(k);
            if (division_active === 1'b0 && prev === 1'b1) falls.push_back(k);
            prev = division_active;
            if (out_valid === 1'b1) outs.push_back(k);
            next_cycle();
        end
        checks++; if (rises.size() != 2 || falls.size() != 2) begin
            errors++; $display("FAIL two_div_edges got %0d rises %0d falls exp 2/2", rises.size(), falls.size());
        end else if (rises[0] != 3 || falls[0] != 16 || rises[1] != 18 || falls[1] != 31) begin
            errors++; $display("FAIL two_div_timing got %0d-%0d,%0d-%0d exp 3-16,18-31", rises[0], falls[0], rises[1], falls[1]);
        end
        checks++; if (outs.size() != 2) begin
            errors++; $display("FAIL two_div_outs got %0d exp 2", outs.size());
        end else if (outs[0] != 18 || outs[1] != 33) begin
            errors++; $display("FAIL two_div_out_cycles got %0d,%0d exp 18,33", outs[0], outs[1]);
        end
    endtask

    task automatic test_flush();
        int ov_cnt;
        ov_cnt = 0;
        out_ready = 1'b0; in_valid = 1'b1; in_division_op = 1'b0;
        next_cycle();                       // add accepted
        in_division_op = 1'b1; next_cycle(); // divide accepted
        in_division_op = 1'b0; next_cycle(); // add accepted
        in_valid = 1'b0;
        repeat (6) next_cycle();            // now in cycle 9: iteration 5
        flush = 1'b1;
        @(negedge clk);
        checks++; if (stage_valid !== 4'b1011 || division_active !== 1'b1 || division_iteration !== 6'd5) begin
            errors++; $display("FAIL flush_setup got sv=%b act=%b it=%0d exp 1011/1/5", stage_valid, division_active, division_iteration);
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
        next_cycle();
        flush = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        checks++; if (stage_valid !== 4'b0000 || stall !== 4'b0000) begin
            errors++; $display("FAIL flush_clear got sv=%b stall=%b exp 0000/0000", stage_valid, stall);
        end
        checks++; if (division_active !== 1'b0 || division_iteration !== 6'd0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_div got act=%b it=%0d rdy=%b exp 0/0/1", division_active, division_iteration, in_ready);
        end
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) ov_cnt++;
            next_cycle();
        end
        checks++; if (ov_cnt != 0) begin errors++; $display("FAIL flush_no_output got %0d exp 0", ov_cnt); end
    endtask

    // Slot model: each stage is a slot holding an op (occupied, is_divide).
    // An op moves forward when the slot ahead is free or being vacated; a
    // divide op sitting in the divide slot must first wait out its timer
    // (one setup cycle plus DI iteration cycles). rem counts cycles left.
    task automatic test_random();
        bit mv[S+1], md[S+1], mov[S+1], nv[S+1], nd[S+1];
        int rem, nrem;
        bit e_rdy, e_act, e_last;
        logic [S-1:0] e_sv, e_st;
        logic [5:0] e_iter;
        do_reset();
        for (int s = 0; s <= S; s++) begin mv[s] = 0; md[s] = 0; mov[s] = 0; end
        rem = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            in_valid       = ($urandom_range(0, 99) < 55);
            in_division_op = ($urandom_range(0, 99) < 20);
            out_ready      = ($urandom_range(0, 99) < 70);
            flush          = ($urandom_range(0, 199) < 2);
            mov[S] = mv[S] && out_ready;
            for (int s = S - 1; s >= 1; s--) begin
                mov[s] = mv[s] && !(s == D && md[s] && rem != 0) && (!mv[s+1] || mov[s+1]);
            end
            e_rdy = !flush && (!mv[1] || mov[1]);
            for (int s = 1; s <= S; s++) begin
                e_sv[s-1] = mv[s];
                e_st[s-1] = mv[s] && !mov[s];
            end
            e_act  = mv[D] && md[D] && rem >= 1 && rem <= DI;
            e_last = e_act && rem == 1;
            e_iter = 6'(DI - rem);
            @(negedge clk);
            checks++; if (stage_valid !== e_sv) begin errors++; $display("FAIL rnd_stage_valid cyc=%0d got %b exp %b", cyc, stage_valid, e_sv); end
            checks++; if (stall !== e_st) begin errors++; $display("FAIL rnd_stall cyc=%0d got %b exp %b", cyc, stall, e_st); end
            checks++; if (in_ready !== e_rdy) begin errors++; $display("FAIL rnd_in_ready cyc=%0d got %b exp %b", cyc, in_ready, e_rdy); end
            checks++; if (out_valid !== mv[S]) begin errors++; $display("FAIL rnd_out_valid cyc=%0d got %b exp %b", cyc, out_valid, mv[S]); end
            checks++; if (division_active !== e_act || division_last !== e_last) begin
                errors++; $display("FAIL rnd_div cyc=%0d got act=%b last=%b exp %b/%b", cyc, division_active, division_last, e_act, e_last);
            end
            if (e_act) begin
                checks++; if (division_iteration !== e_iter) begin
                    errors++; $display("FAIL rnd_iteration cyc=%0d got %0d exp %0d", cyc, division_iteration, e_iter);
                end
            end
            if (flush) begin
                for (int s = 0; s <= S; s++) begin mv[s] = 0; md[s] = 0; end
                rem = 0;
            end else begin
                for (int s = 0; s <= S; s++) begin nv[s] = 0; nd[s] = 0; end
                for (int s = S; s >= 1; s--) begin
                    if (mov[s]) begin
                        if (s < S) begin nv[s+1] = 1; nd[s+1] = md[s]; end
                    end else if (mv[s]) begin
                        nv[s] = 1; nd[s] = md[s];
                    end
                end
                if (in_valid && e_rdy) begin nv[1] = 1; nd[1] = in_division_op; end
                if (mov[D-1] && md[D-1]) nrem = DI + 1;
                else if (mv[D] && md[D] && !mov[D] && rem > 0) nrem = rem - 1;
                else nrem = rem;
                for (int s = 0; s <= S; s++) begin mv[s] = nv[s]; md[s] = nd[s]; end
                rem = nrem;
            end
            next_cycle();
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_back_to_back();
        test_single_divide();
        test_add_behind_divide();
        test_two_divides();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
